wb_uart_tx: RTL and testbench

- Wishbone-fed UART transmitter. The host pushes bytes through a reduced Wishbone slave port into an internal FIFO. A frame FSM pops each byte and serializes it as 8N1 on uart_tx, LSB first, using an internal baud counter.
- This block is the transmit companion to the UART receive path. It shares the same baud-rate parameterization and bus style.

---
 rtl/wb_uart_tx_if.sv | 20 ++
 rtl/wb_uart_tx.sv | 136 +++++++++++++
 tb/tb_wb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_tx_if.sv
// Reduced Wishbone slave bus for the UART transmitter: byte push and status read.
interface wb_uart_tx_if;
  logic       i_wb_cyc;
  logic       i_wb_stb;
  logic       i_wb_we;
  logic [7:0] i_wb_data;
  logic [7:0] o_wb_data;
  logic       o_wb_ack;
  logic       o_wb_stall;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_data,
    input  o_wb_data, o_wb_ack, o_wb_stall
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_data,
    output o_wb_data, o_wb_ack, o_wb_stall
  );
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone-fed 8N1 UART transmitter: bus pushes bytes into a FIFO, a frame
// FSM pops them and shifts them out LSB first at BAUD_DIV_RATE clocks per bit.
module wb_uart_tx #(
  parameter int BAUD_DIV_RATE  = 2604,
  parameter int BAUD_DIV_WIDTH = 12,
  parameter int FIFO_AW        = 5,
  parameter int FIFO_DW        = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  wb_uart_tx_if.slave wb,
  output logic        uart_tx,
  output logic        uart_busy,
  output logic        uart_full
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_LAST = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);
  localparam logic [FIFO_AW:0]          CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       full;
    logic       empty;
    logic       busy;
  } wb_status_t;

  // FIFO
  logic [FIFO_DW-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_full, fifo_empty;
  logic               accept, push, pop;

  // frame engine
  state_t                    state, state_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt, baud_d;
  logic [3:0]                bit_cnt, bit_d;
  logic [FIFO_DW+1:0]        shifter, shift_d;
  wb_status_t                status;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign uart_full  = fifo_full;
  assign uart_busy  = (state != IDLE) || !fifo_empty;

  assign wb.o_wb_stall = fifo_full;
  assign accept        = wb.i_wb_cyc && wb.i_wb_stb && !fifo_full;
  assign push          = accept && wb.i_wb_we;

  assign status = '{rsvd: 5'b0, full: fifo_full, empty: fifo_empty, busy: uart_busy};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= '0;
    end else begin
      wb.o_wb_ack <= accept;
      if (accept && !wb.i_wb_we) wb.o_wb_data <= status;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked solely by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wb.i_wb_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shifter  <= shift_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shift_d = shifter;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        shift_d = '1;
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        pop     = 1'b1;
        shift_d = {1'b1, mem[rd_ptr], 1'b0};
        baud_d  = '0;
        bit_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shifter[FIFO_DW+1:1]};
          bit_d   = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_d = IDLE;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '1;
      end
    endcase
  end

  // Line driven straight from a flop so it never glitches; all-ones when idle.
  assign uart_tx = shifter[0];

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: frame-schedule reference model, vector table, directed corners, random traffic.
module tb_wb_uart_tx;
  localparam int R     = 5;
  localparam int DEPTH = 32;

  logic clk, rst;
  logic tx, busy, full;

  wb_uart_tx_if bus ();

  wb_uart_tx #(
    .BAUD_DIV_RATE (R),
    .BAUD_DIV_WIDTH(12),
    .FIFO_AW       (5),
    .FIFO_DW       (8)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .wb       (bus),
    .uart_tx  (tx),
    .uart_busy(busy),
    .uart_full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model: each accepted byte gets a scheduled frame start cycle
  int         frames_s[$];
  logic [7:0] frames_b[$];
  logic [7:0] acc_bytes[$];
  int         mcount = 0;
  int         last_s = -100000;
  logic       exp_ack = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  logic       trace[$];
  logic [7:0] dec[$];
  int         dec_st[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic m_busy(input int c);
    if (mcount > 0) return 1'b1;
    foreach (frames_s[i])
      if (c >= frames_s[i] - 1 && c <= frames_s[i] + 10*R - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(input int c);
    int k;
    foreach (frames_s[i]) begin
      if (c >= frames_s[i] && c < frames_s[i] + 10*R) begin
        k = (c - frames_s[i]) / R;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return frames_b[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  // one clock: predict, advance the model at the edge, compare #1 later
  task automatic step();
    logic       acc, st_full, st_empty;
    logic [7:0] st;
    int         s;
    st_full  = (mcount == DEPTH);
    st_empty = (mcount == 0);
    acc = !rst && bus.i_wb_cyc && bus.i_wb_stb && !st_full;
    st  = {5'b0, st_full, st_empty, m_busy(cyc_n)};
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      frames_s.delete();
      frames_b.delete();
      mcount    = 0;
      last_s    = -100000;
      exp_ack   = 1'b0;
      exp_rdata = 8'h00;
    end else begin
      exp_ack = acc;
      if (acc && !bus.i_wb_we) exp_rdata = st;
      foreach (frames_s[i]) if (frames_s[i] == cyc_n) mcount--;
      if (acc && bus.i_wb_we) begin
        s = (cyc_n + 2 > last_s + 10*R + 2) ? cyc_n + 2 : last_s + 10*R + 2;
        frames_s.push_back(s);
        frames_b.push_back(bus.i_wb_data);
        acc_bytes.push_back(bus.i_wb_data);
        last_s = s;
        mcount++;
      end
    end
    #1;
    chk("ack",   32'(bus.o_wb_ack),   32'(exp_ack));
    chk("rdata", 32'(bus.o_wb_data),  32'(exp_rdata));
    chk("stall", 32'(bus.o_wb_stall), 32'(mcount == DEPTH));
    chk("full",  32'(full),           32'(mcount == DEPTH));
    chk("busy",  32'(busy),           32'(m_busy(cyc_n)));
    chk("tx",    32'(tx),             32'(m_tx(cyc_n)));
    trace.push_back(tx);
  endtask

  task automatic bus_op(input logic we, input logic [7:0] d, output logic [7:0] rd, output int waits);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_data = d;
    waits = 0;
    do begin
      step();
      waits++;
    end while (bus.o_wb_ack !== 1'b1 && waits < 300);
    chk("bus_ack_timeout", 32'(bus.o_wb_ack), 32'd1);
    rd = bus.o_wb_data;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mcount > 0 || m_busy(cyc_n)) && n < budget) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic decode_trace();
    int         i;
    logic [7:0] b;
    dec.delete();
    dec_st.delete();
    i = 1;
    while (i + 10*R <= trace.size()) begin
      if (trace[i] === 1'b0 && trace[i-1] === 1'b1) begin
        for (int k = 0; k < 8; k++) b[k] = trace[i + R*(k+1) + R/2];
        dec.push_back(b);
        dec_st.push_back(i);
        i += 10*R;
      end else begin
        i++;
      end
    end
  endtask

  typedef struct {
    logic       cyc, stb, we;
    logic [7:0] d;
    logic       exp_ack;
    logic [7:0] exp_rd;
    logic       exp_busy;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    logic [7:0] rd;
    int         w, base, zeros, r;

    tbl[0] = '{cyc:1'b0, stb:1'b1, we:1'b1, d:8'hAA, exp_ack:1'b0, exp_rd:8'h00, exp_busy:1'b0};
    tbl[1] = '{cyc:1'b1, stb:1'b0, we:1'b1, d:8'h5A, exp_ack:1'b0, exp_rd:8'h00, exp_busy:1'b0};
    tbl[2] = '{cyc:1'b1, stb:1'b1, we:1'b0, d:8'h00, exp_ack:1'b1, exp_rd:8'h02, exp_busy:1'b0};
    tbl[3] = '{cyc:1'b0, stb:1'b1, we:1'b0, d:8'h00, exp_ack:1'b0, exp_rd:8'h02, exp_busy:1'b0};
    tbl[4] = '{cyc:1'b1, stb:1'b1, we:1'b0, d:8'h00, exp_ack:1'b1, exp_rd:8'h02, exp_busy:1'b0};
    tbl[5] = '{cyc:1'b0, stb:1'b0, we:1'b0, d:8'h00, exp_ack:1'b0, exp_rd:8'h02, exp_busy:1'b0};

    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_data = 8'h00;

    // reset state
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_ack",   32'(bus.o_wb_ack),   32'd0);
    chk("rst_rdata", 32'(bus.o_wb_data),  32'd0);
    chk("rst_stall", 32'(bus.o_wb_stall), 32'd0);
    chk("rst_tx",    32'(tx),             32'd1);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_full",  32'(full),           32'd0);
    rst = 1'b0;
    step();

    // single-cycle bus vectors on an empty, idle block
    for (int i = 0; i < 6; i++) begin
      bus.i_wb_cyc  = tbl[i].cyc;
      bus.i_wb_stb  = tbl[i].stb;
      bus.i_wb_we   = tbl[i].we;
      bus.i_wb_data = tbl[i].d;
      step();
      chk("tbl_ack",   32'(bus.o_wb_ack),  32'(tbl[i].exp_ack));
      chk("tbl_rdata", 32'(bus.o_wb_data), 32'(tbl[i].exp_rd));
      chk("tbl_busy",  32'(busy),          32'(tbl[i].exp_busy));
    end
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("cyc0_no_frame_busy", 32'(busy), 32'd0);

    // 0x55: start bit three cycles after the accept cycle, 5 cycles per bit
    trace.delete();
    bus_op(1'b1, 8'h55, rd, w);
    chk("w55_immediate", 32'(w), 32'd1);
    base = trace.size() - 1;
    for (int i = 0; i < 60; i++) step();
    for (int i = 0; i < 50; i++)
      chk("w55_wave", 32'(trace[base + 2 + i]), 32'((i / 5) % 2));
    for (int i = 52; i <= 60; i++)
      chk("w55_idle_high", 32'(trace[base + i]), 32'd1);
    chk("w55_busy_after", 32'(busy), 32'd0);

    // back-to-back frames: stop stretched by the IDLE+LOAD cycles
    trace.delete();
    bus_op(1'b1, 8'hA3, rd, w);
    bus_op(1'b1, 8'h0F, rd, w);
    drain(400);
    decode_trace();
    chk("b2b_count", 32'(dec.size()), 32'd2);
    if (dec.size() == 2) begin
      chk("b2b_byte0", 32'(dec[0]), 32'hA3);
      chk("b2b_byte1", 32'(dec[1]), 32'h0F);
      chk("b2b_start_gap", 32'(dec_st[1] - dec_st[0]), 32'(10*R + 2));
    end

    // fill to full while a frame is in flight, stalled read and stalled write
    trace.delete();
    bus_op(1'b1, 8'h7E, rd, w);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 32; i++) begin
      bus_op(1'b1, 8'(i), rd, w);
      chk("fill_no_wait", 32'(w), 32'd1);
    end
    chk("full_flag",  32'(full),           32'd1);
    chk("full_stall", 32'(bus.o_wb_stall), 32'd1);
    bus_op(1'b0, 8'h00, rd, w);
    chk("full_read_waited", 32'(w > 1), 32'd1);
    chk("full_read_status", 32'(rd), 32'h01);
    bus_op(1'b1, 8'h20, rd, w);
    chk("refill_no_wait", 32'(w), 32'd1);
    bus_op(1'b1, 8'h21, rd, w);
    chk("stalled_write_waited", 32'(w > 1), 32'd1);
    drain(3000);
    decode_trace();
    chk("wrap_count", 32'(dec.size()), 32'd35);
    if (dec.size() == 35) begin
      chk("wrap_lead", 32'(dec[0]), 32'h7E);
      for (int i = 0; i < 34; i++) chk("wrap_order", 32'(dec[i+1]), 32'(i));
    end

    // reset in the middle of a data bit of 0xFF with another byte queued
    bus_op(1'b1, 8'hFF, rd, w);
    bus_op(1'b1, 8'h12, rd, w);
    for (int i = 0; i < 2 + 3*R; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_tx",   32'(tx),   32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_full", 32'(full), 32'd0);
    trace.delete();
    for (int i = 0; i < 100; i++) step();
    zeros = 0;
    foreach (trace[i]) if (trace[i] !== 1'b1) zeros++;
    chk("midrst_no_frame", 32'(zeros), 32'd0);
    bus_op(1'b0, 8'h00, rd, w);
    chk("midrst_status", 32'(rd), 32'h02);

    // random traffic against the frame-schedule model
    trace.delete();
    acc_bytes.delete();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      bus.i_wb_cyc  = (r <= 2) || (r == 3 ? 1'b0 : 1'b0);
      bus.i_wb_stb  = (r <= 3);
      bus.i_wb_we   = (r <= 1) || (r == 3);
      bus.i_wb_data = 8'($urandom);
      step();
    end
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    drain(6000);
    decode_trace();
    chk("rand_count", 32'(dec.size()), 32'(acc_bytes.size()));
    if (dec.size() == acc_bytes.size())
      foreach (dec[i]) chk("rand_byte", 32'(dec[i]), 32'(acc_bytes[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
